norm_left_shifter: RTL and testbench
====================================

Name: norm_left_shifter

Overview:
- Post-add normalization block for the FP add/sub datapath, the counterpart of the alignment barrel shifter.
- The alignment shifter takes a shift amount and right-shifts the mantissa. This block finds the leading-zero count of a raw sum mantissa itself, then left-shifts the mantissa so its MSB lands in bit SWR-1.
- It reports the applied shift amount so the exponent path can subtract it.
- Fully pipelined: 3 stages, one operand accepted per cycle.

Parameters:
- SWR, 26, mantissa/datapath width in bits.
- EWR, 5, width of shift-amount fields; must satisfy 2**EWR > SWR (checked by elaboration assertion).

Ports:
- clk  input  1  clock, all registers rising-edge.
- rst  input  1  asynchronous, active-high reset.
- load_i  input  1  operand valid; samples Data_i and Max_Shift_i this cycle.
- Data_i  input  SWR  unnormalized mantissa.
- Max_Shift_i  input  EWR  maximum permitted left shift (exponent headroom for denormal results).
- Valid_o  output  1  result valid, pulses 3 cycles after load_i.
- N_mant_o  output  SWR  normalized (or limit-shifted) mantissa.
- Shift_Value_o  output  EWR  left shift actually applied.
- Zero_o  output  1  Data_i was all zeros.
- Limit_o  output  1  shift was clamped by Max_Shift_i.

Behaviour:
- Reset (async, rst=1): all pipeline valid bits and every output register clear immediately.
  - Valid_o=0, N_mant_o=0, Shift_Value_o=0, Zero_o=0, Limit_o=0.
  - In-flight operands are discarded; no output appears for them after rst deasserts.
- Stage 1 (cycle after load_i): register Data_i, Max_Shift_i and v1=load_i.
- Stage 2 (LZD and clamp):
  - lzc = number of leading zeros from bit SWR-1 (0..SWR-1 for nonzero data).
  - zero = (data==0).
  - shamt = zero ? 0 : min(lzc, Max_Shift).
  - limit = !zero && (lzc > Max_Shift).
  - Register data, shamt, zero, limit and v2.
- Stage 3 (left shift):
  - N_mant = data << shamt, zero-filled from the LSB.
  - Implemented as log2 binary stages (1,2,4,8,16), combinational within the stage.
  - Register all outputs and Valid_o=v2.
- Latency: load_i at edge N produces Valid_o high after edge N+3.
- Throughput: 1 per cycle; there is no backpressure, so results stream out in input order.
- Output hold: when Valid_o=0, output data registers hold their last value. Consumers qualify with Valid_o.
- Boundary conditions:
  - Data MSB already set: shamt=0, N_mant=Data.
  - Data all zero: Zero_o=1, Shift_Value_o=0, N_mant_o=0, Limit_o=0.
  - Max_Shift_i=0: no shift; Limit_o=1 if MSB clear and data nonzero.
  - Max_Shift_i >= SWR: never clamps.
- Bubbles: load_i gaps propagate as Valid_o gaps, with no reordering or merging.

Decomposition:
- Shared FP package holds:
  - default SWR/EWR constants (26/5 single precision, 55/6 double);
  - a function clog2;
  - the elaboration check 2**EWR > SWR.
- Natural sub-module: lzd_priority_enc (parameterized SWR -> EWR count plus zero flag), reusable by the multiplier normalizer.
- The stage-3 shifter stays inline; it is a fixed-direction log shifter, not the bidirectional shifter.

Test Plan (SWR=26, EWR=5, Max_Shift_i=31 unless stated):
- Data_i=26'h0800000 (bit 23) -> 3 cycles later: Valid_o=1, Shift_Value_o=2, N_mant_o=26'h2000000, Zero_o=0, Limit_o=0.
- Data_i=26'h0000001 -> Shift_Value_o=25, N_mant_o=26'h2000000; Data_i=26'h3FFFFFF -> Shift_Value_o=0, N_mant_o unchanged.
- Data_i=0 -> Zero_o=1, Shift_Value_o=0, N_mant_o=0, Limit_o=0.
- Data_i=26'h0000010, Max_Shift_i=3 -> Shift_Value_o=3, N_mant_o=26'h0000080, Limit_o=1.
- Back-to-back loads of 26'h1000000, 26'h0000100, 0 on consecutive cycles -> Valid_o high 3 consecutive cycles.
  - Shifts, in order: 1, 17, 0(Zero_o=1).
  - A random 1000-vector sweep is compared against a reference model.
- load_i at cycle 0, rst pulsed during cycle 2 -> Valid_o never asserts for that operand, all outputs read 0 during and after reset until the next load.

Source files
------------

// File: rtl/norm_left_shifter_pkg.sv
// Shared FP datapath constants and helpers for the add/sub normalization path.
// Also used by the multiplier normalizer through lzd_priority_enc.
package norm_left_shifter_pkg;

    localparam int SWR_SP = 26;
    localparam int EWR_SP = 5;
    localparam int SWR_DP = 55;
    localparam int EWR_DP = 6;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    // A shift field of ewr bits must encode every count 0..swr, i.e. 2**ewr > swr.
    function automatic bit shift_width_ok(input int swr, input int ewr);
        return ewr >= clog2(swr + 1);
    endfunction

endpackage

// File: rtl/norm_left_shifter_lzd.sv
// Leading-zero priority encoder: counts zeros down from bit SWR-1 and flags all-zero input.
// Reusable by any normalizer that needs an EWR-bit shift count.
module lzd_priority_enc #(
    parameter int SWR = 26,
    parameter int EWR = 5
) (
    input  logic [SWR-1:0] i_data,
    output logic [EWR-1:0] o_count,
    output logic           o_zero
);

    // Scanning upward lets the highest set bit overwrite every lower one.
    always_comb begin
        o_count = '0;
        o_zero  = (i_data == '0);
        for (int i = 0; i < SWR; i++) begin
            if (i_data[i]) begin
                o_count = EWR'(SWR - 1 - i);
            end
        end
    end

endmodule

// File: rtl/norm_left_shifter.sv
// Three-stage post-add normalizer: register, leading-zero detect with clamp, log left shift.
// Valid_o follows load_i by three cycles with no backpressure; outputs hold while Valid_o is low.
module norm_left_shifter
    import norm_left_shifter_pkg::*;
#(
    parameter int SWR = SWR_SP,
    parameter int EWR = EWR_SP
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load_i,
    input  logic [SWR-1:0] Data_i,
    input  logic [EWR-1:0] Max_Shift_i,
    output logic           Valid_o,
    output logic [SWR-1:0] N_mant_o,
    output logic [EWR-1:0] Shift_Value_o,
    output logic           Zero_o,
    output logic           Limit_o
);

    if (!shift_width_ok(SWR, EWR)) begin : g_bad_width
        $error("norm_left_shifter: 2**EWR must exceed SWR");
    end

    logic           r_v1;
    logic [SWR-1:0] r_data1;
    logic [EWR-1:0] r_max1;

    logic           r_v2;
    logic [SWR-1:0] r_data2;
    logic [EWR-1:0] r_shamt2;
    logic           r_zero2;
    logic           r_limit2;

    logic [EWR-1:0] w_lzc;
    logic           w_zero;
    logic           w_limit;
    logic [EWR-1:0] w_shamt;
    logic [SWR-1:0] w_shift [EWR+1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v1    <= 1'b0;
            r_data1 <= '0;
            r_max1  <= '0;
        end else begin
            r_v1 <= load_i;
            if (load_i) begin
                r_data1 <= Data_i;
                r_max1  <= Max_Shift_i;
            end
        end
    end

    lzd_priority_enc #(
        .SWR(SWR),
        .EWR(EWR)
    ) u_lzd (
        .i_data (r_data1),
        .o_count(w_lzc),
        .o_zero (w_zero)
    );

    // Exponent headroom caps the shift; the result is then left denormal.
    assign w_limit = !w_zero && (w_lzc > r_max1);
    assign w_shamt = w_zero ? '0 : (w_limit ? r_max1 : w_lzc);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v2     <= 1'b0;
            r_data2  <= '0;
            r_shamt2 <= '0;
            r_zero2  <= 1'b0;
            r_limit2 <= 1'b0;
        end else begin
            r_v2 <= r_v1;
            if (r_v1) begin
                r_data2  <= r_data1;
                r_shamt2 <= w_shamt;
                r_zero2  <= w_zero;
                r_limit2 <= w_limit;
            end
        end
    end

    assign w_shift[0] = r_data2;
    for (genvar k = 0; k < EWR; k++) begin : g_log_shift
        assign w_shift[k+1] = r_shamt2[k] ? (w_shift[k] << (2 ** k)) : w_shift[k];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Valid_o       <= 1'b0;
            N_mant_o      <= '0;
            Shift_Value_o <= '0;
            Zero_o        <= 1'b0;
            Limit_o       <= 1'b0;
        end else begin
            Valid_o <= r_v2;
            if (r_v2) begin
                N_mant_o      <= w_shift[EWR];
                Shift_Value_o <= r_shamt2;
                Zero_o        <= r_zero2;
                Limit_o       <= r_limit2;
            end
        end
    end

endmodule

// File: tb/tb_norm_left_shifter.sv
// Scoreboard bench for norm_left_shifter: directed vectors, back-to-back and bubbled random
// traffic, and a reset that discards an in-flight operand.
module tb_norm_left_shifter;

    localparam int SWR = 26;
    localparam int EWR = 5;
    localparam int W   = SWR + EWR + 2;

    logic           clk;
    logic           rst;
    logic           load_i;
    logic [SWR-1:0] Data_i;
    logic [EWR-1:0] Max_Shift_i;
    logic           Valid_o;
    logic [SWR-1:0] N_mant_o;
    logic [EWR-1:0] Shift_Value_o;
    logic           Zero_o;
    logic           Limit_o;

    int check_count;
    int error_count;
    int cyc;

    logic [W-1:0] exp_q[$];
    int           due_q[$];

    norm_left_shifter #(
        .SWR(SWR),
        .EWR(EWR)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .load_i       (load_i),
        .Data_i       (Data_i),
        .Max_Shift_i  (Max_Shift_i),
        .Valid_o      (Valid_o),
        .N_mant_o     (N_mant_o),
        .Shift_Value_o(Shift_Value_o),
        .Zero_o       (Zero_o),
        .Limit_o      (Limit_o)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- checker ----------------
    task automatic check_val(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        check_count = check_count + 1;
        if (observed !== expected) begin
            error_count = error_count + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, observed, expected, cyc);
        end
    endtask

    // Reference model: count zeros from the MSB, clamp, shift.
    function automatic logic [W-1:0] ref_model(input logic [SWR-1:0] d, input logic [EWR-1:0] m);
        int             lz;
        bit             found;
        logic           z;
        logic           lim;
        int             sh;
        logic [SWR-1:0] mant;
        lz    = 0;
        found = 0;
        for (int i = SWR - 1; i >= 0; i--) begin
            if (!found && d[i] == 1'b0) lz = lz + 1;
            else found = 1;
        end
        z    = (d == '0);
        lim  = !z && (lz > int'(m));
        sh   = z ? 0 : (lim ? int'(m) : lz);
        mant = d << sh;
        return {mant, EWR'(sh), z, lim};
    endfunction

    // ---------------- drivers ----------------
    task automatic drive(input logic [SWR-1:0] d, input logic [EWR-1:0] m);
        @(negedge clk);
        load_i      = 1'b1;
        Data_i      = d;
        Max_Shift_i = m;
        exp_q.push_back(ref_model(d, m));
        due_q.push_back(cyc + 3);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            load_i = 1'b0;
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check_val({tag, "_valid"}, 64'(Valid_o), 64'd0);
        check_val({tag, "_mant"},  64'(N_mant_o), 64'd0);
        check_val({tag, "_shift"}, 64'(Shift_Value_o), 64'd0);
        check_val({tag, "_zero"},  64'(Zero_o), 64'd0);
        check_val({tag, "_limit"}, 64'(Limit_o), 64'd0);
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(posedge clk) begin
        logic [W-1:0] e;
        logic         exp_valid;
        #1;
        exp_valid = (due_q.size() > 0) && (due_q[0] == cyc);
        check_val("valid", 64'(Valid_o), 64'(exp_valid));
        if (exp_valid) begin
            e = exp_q.pop_front();
            void'(due_q.pop_front());
            if (Valid_o) begin
                check_val("n_mant", 64'(N_mant_o), 64'(e[W-1 -: SWR]));
                check_val("shift",  64'(Shift_Value_o), 64'(e[EWR+1:2]));
                check_val("zero",   64'(Zero_o), 64'(e[1]));
                check_val("limit",  64'(Limit_o), 64'(e[0]));
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [SWR-1:0] d;
        logic [EWR-1:0] m;
        int             waited;
        check_count = 0;
        error_count = 0;
        rst         = 1'b1;
        load_i      = 1'b0;
        Data_i      = '0;
        Max_Shift_i = '0;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // Directed vectors
        drive(26'h0800000, 5'd31);
        idle(3);
        drive(26'h0000001, 5'd31);
        drive(26'h3FFFFFF, 5'd31);
        drive(26'h0000000, 5'd31);
        drive(26'h0000010, 5'd3);
        drive(26'h0000010, 5'd0);
        drive(26'h2000000, 5'd0);
        drive(26'h0000040, 5'd26);
        idle(4);

        // Back-to-back, Valid_o must stay high three cycles
        drive(26'h1000000, 5'd31);
        drive(26'h0000100, 5'd31);
        drive(26'h0000000, 5'd31);
        idle(5);

        // Random sweep with bubbles
        for (int n = 0; n < 1000; n++) begin
            if ($urandom_range(0, 3) == 0) idle(1);
            d = SWR'($urandom) >> $urandom_range(0, SWR);
            m = ($urandom_range(0, 1) == 1) ? 5'd31 : EWR'($urandom_range(0, 31));
            drive(d, m);
        end
        idle(6);

        // Reset with an operand in flight: nothing may emerge for it
        drive(26'h0000001, 5'd31);
        idle(5);
        drive(26'h0000003, 5'd31);
        idle(2);
        rst = 1'b1;
        exp_q.delete();
        due_q.delete();
        #1;
        check_outputs_zero("rst_async");
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check_outputs_zero("post_rst");
        end

        drive(26'h0400000, 5'd31);
        idle(1);

        waited = 0;
        while (exp_q.size() > 0 && waited < 20) begin
            @(posedge clk);
            waited = waited + 1;
        end
        #2;
        check_val("drain", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
